// File: rtl/apb_slave_pkg.sv
// Shared types and address decode for the APB register-file completer.
package apb_slave_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_phase_e;

    typedef struct packed {
        logic       hit;
        logic [7:0] idx;
    } apb_decode_t;

    // Window compare is done one bit wider so a window ending at 4 GiB cannot wrap.
    function automatic apb_decode_t apb_decode(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input int                    num_regs
    );
        apb_decode_t           d;
        logic [APB_ADDR_W-1:0] span;
        logic [APB_ADDR_W:0]   limit;
        span  = APB_ADDR_W'(num_regs) << 2;
        limit = {1'b0, base} + {1'b0, span};
        d.hit = (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < limit);
        d.idx = addr[9:2] & 8'(num_regs - 1);
        return d;
    endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB phase tracker: latches the setup-phase address/direction and flags sequencing
// and stability violations.
module apb_slave_fsm
    import apb_slave_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    output logic                  setup_evt,
    output logic                  access_evt,
    output logic                  proto_viol,
    output logic [APB_ADDR_W-1:0] lat_addr,
    output logic                  lat_write
);

    apb_phase_e state;
    apb_phase_e state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_write <= 1'b0;
        end else begin
            state <= state_nxt;
            if (setup_evt) begin
                lat_addr  <= paddr;
                lat_write <= pwrite;
            end
        end
    end

    // access_evt fires only for a clean SETUP->ACCESS hand-off; an unstable one is aborted.
    always_comb begin
        state_nxt  = state;
        setup_evt  = 1'b0;
        access_evt = 1'b0;
        proto_viol = 1'b0;
        case (state)
            IDLE: begin
                if (pselx && !penable) begin
                    state_nxt = SETUP;
                    setup_evt = 1'b1;
                end else if (pselx && penable) begin
                    proto_viol = 1'b1;
                end
            end
            SETUP: begin
                if (pselx && penable) begin
                    state_nxt = ACCESS;
                    if ((paddr == lat_addr) && (pwrite == lat_write)) begin
                        access_evt = 1'b1;
                    end else begin
                        proto_viol = 1'b1;
                    end
                end else begin
                    proto_viol = 1'b1;
                    if (pselx) begin
                        state_nxt = SETUP;
                        setup_evt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            ACCESS: begin
                if (!pselx) begin
                    state_nxt = IDLE;
                end else if (!penable) begin
                    state_nxt = SETUP;
                    setup_evt = 1'b1;
                end else begin
                    proto_viol = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB2 completer with a bank of 32-bit registers, sticky protocol/decode error flags
// and saturating transfer counters.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pselx,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [31:0]      paddr,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    input  logic             err_clr,
    output logic             proto_err,
    output logic             decode_err,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    logic                  setup_evt;
    logic                  access_evt;
    logic                  proto_viol;
    logic [APB_ADDR_W-1:0] lat_addr;
    logic                  lat_write;
    apb_decode_t           setup_dec;
    apb_decode_t           access_dec;
    logic                  unused_idx;

    apb_slave_fsm u_fsm (
        .clock      (clock),
        .reset      (reset),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .setup_evt  (setup_evt),
        .access_evt (access_evt),
        .proto_viol (proto_viol),
        .lat_addr   (lat_addr),
        .lat_write  (lat_write)
    );

    // Reads decode the live setup address; writes and counters use the latched one.
    assign setup_dec  = apb_decode(paddr, BASE_ADDR, NUM_REGS);
    assign access_dec = apb_decode(lat_addr, BASE_ADDR, NUM_REGS);
    assign unused_idx = ^{setup_dec.idx, access_dec.idx};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            prdata <= '0;
        end else begin
            if (access_evt && access_dec.hit && lat_write) begin
                regs[access_dec.idx[IDX_W-1:0]] <= pwdata;
            end
            if (setup_evt && !pwrite) begin
                prdata <= setup_dec.hit ? regs[setup_dec.idx[IDX_W-1:0]] : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (access_evt && access_dec.hit) begin
            if (lat_write && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (!lat_write && (rd_count != '1)) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end

    // A fresh error in the err_clr cycle keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err  <= 1'b0;
            decode_err <= 1'b0;
        end else begin
            proto_err  <= proto_viol | (proto_err & ~err_clr);
            decode_err <= (access_evt & ~access_dec.hit) | (decode_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: directed vector table, protocol/reset corner sequences and
// randomized transfers checked against a transaction-level register model.
module tb_apb_slave_regfile;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             pselx;
    logic             penable;
    logic             pwrite;
    logic             err_clr;
    logic [31:0]      paddr;
    logic [31:0]      pwdata;
    logic [31:0]      prdata;
    logic             proto_err;
    logic             decode_err;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] rd_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_regs [NUM_REGS];
    int          model_wr;
    int          model_rd;
    bit          model_dec;

    typedef struct {
        bit          wr;
        bit          clr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        bit          exp_dec;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs [8];

    always #5 clock = ~clock;

    apb_slave_regfile #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE),
        .CNT_W     (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .err_clr    (err_clr),
        .proto_err  (proto_err),
        .decode_err (decode_err),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    task automatic applyStimulus(input logic rst, input logic psel, input logic pen,
                                 input logic pwr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic clr);
        reset   = rst;
        pselx   = psel;
        penable = pen;
        pwrite  = pwr;
        paddr   = addr;
        pwdata  = data;
        err_clr = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idleCycle(input logic clr);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, clr);
        if (clr) model_dec = 1'b0;
    endtask

    function automatic bit modelHit(input logic [31:0] a);
        longint unsigned ua;
        ua = longint'(a);
        return (ua % 4 == 0) && (ua >= longint'(BASE)) &&
               (ua < longint'(BASE) + NUM_REGS * 4);
    endfunction

    function automatic int modelIdx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
        model_wr  = 0;
        model_rd  = 0;
        model_dec = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " wr_count"}, 32'(wr_count), 32'(model_wr));
        checkOutput({tag, " rd_count"}, 32'(rd_count), 32'(model_rd));
        checkOutput({tag, " decode_err"}, 32'(decode_err), 32'(model_dec));
    endtask

    // One complete setup+access transfer; pwdata carries junk during setup on purpose.
    task automatic busTxn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input string tag);
        logic [31:0] exp;
        bit          hit;
        hit = modelHit(addr);
        exp = hit ? model_regs[modelIdx(addr)] : 32'h0;
        applyStimulus(1'b0, 1'b1, 1'b0, wr, addr, ~data, 1'b0);
        if (!wr) checkOutput({tag, " prdata"}, prdata, exp);
        applyStimulus(1'b0, 1'b1, 1'b1, wr, addr, data, 1'b0);
        if (hit) begin
            if (wr) begin
                model_regs[modelIdx(addr)] = data;
                if (model_wr < CNT_MAX) model_wr++;
            end else begin
                if (model_rd < CNT_MAX) model_rd++;
            end
        end else begin
            model_dec = 1'b1;
        end
        if (!wr) checkOutput({tag, " prdata hold"}, prdata, exp);
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return BASE + 32'(4 * $urandom_range(0, NUM_REGS - 1));
        if (r == 7) return BASE + 32'(4 * $urandom_range(0, NUM_REGS - 1)) + 32'($urandom_range(1, 3));
        if (r == 8) return BASE + 32'(NUM_REGS * 4) + 32'(4 * $urandom_range(0, 255));
        return BASE - 32'(4 * $urandom_range(1, 64));
    endfunction

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 0};
        vecs[1] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h8000_0040, 32'h0,         32'h0,         1'b1, 1, 1};
        vecs[3] = '{1'b1, 1'b1, 32'h8000_0006, 32'h0BAD_F00D, 32'h0,         1'b1, 1, 1};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_003C, 32'hA5A5_0001, 32'h0,         1'b0, 2, 1};
        vecs[5] = '{1'b0, 1'b0, 32'h8000_003C, 32'h0,         32'hA5A5_0001, 1'b0, 2, 2};
        vecs[6] = '{1'b0, 1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0,         1'b1, 2, 2};
        vecs[7] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1, 2, 3};

        // Reset values.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        modelReset();
        checkOutput("reset prdata", prdata, 32'h0);
        checkOutput("reset proto_err", 32'(proto_err), 32'h0);
        checkModel("reset");
        idleCycle(1'b0);

        // Directed vector table, back-to-back except where an err_clr cycle is requested.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr) begin
                idleCycle(1'b1);
                checkOutput($sformatf("vec%0d clr decode_err", i), 32'(decode_err), 32'h0);
            end
            busTxn(vecs[i].wr, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
            if (!vecs[i].wr) checkOutput($sformatf("vec%0d table prdata", i), prdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d table decode_err", i), 32'(decode_err), 32'(vecs[i].exp_dec));
            checkOutput($sformatf("vec%0d table wr_count", i), 32'(wr_count), 32'(vecs[i].exp_wr));
            checkOutput($sformatf("vec%0d table rd_count", i), 32'(rd_count), 32'(vecs[i].exp_rd));
        end
        idleCycle(1'b0);

        // Whole bank readback: misaligned write must not have landed anywhere.
        for (int i = 0; i < NUM_REGS; i++) begin
            busTxn(1'b0, BASE + 32'(4 * i), 32'h0, $sformatf("readback%0d", i));
        end
        idleCycle(1'b0);
        checkModel("readback");

        // Access without setup.
        idleCycle(1'b1);
        checkOutput("pre-proto proto_err", 32'(proto_err), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'd20, 32'hFEED_0005, 1'b0);
        checkOutput("no-setup proto_err", 32'(proto_err), 32'h1);
        idleCycle(1'b0);
        checkModel("no-setup");
        busTxn(1'b0, BASE + 32'd20, 32'h0, "no-setup reg5");
        idleCycle(1'b1);
        checkOutput("clr proto_err", 32'(proto_err), 32'h0);

        // Address changes between setup and access.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'd24, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'd28, 32'h0000_0077, 1'b0);
        checkOutput("unstable proto_err", 32'(proto_err), 32'h1);
        idleCycle(1'b0);
        checkModel("unstable");
        busTxn(1'b0, BASE + 32'd24, 32'h0, "unstable reg6");
        busTxn(1'b0, BASE + 32'd28, 32'h0, "unstable reg7");
        idleCycle(1'b0);

        // err_clr coincident with new violations.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, BASE, 32'h0, 1'b1);
        checkOutput("clr+viol proto_err", 32'(proto_err), 32'h1);
        idleCycle(1'b1);
        checkOutput("clr after proto_err", 32'(proto_err), 32'h0);
        busTxn(1'b0, BASE + 32'h100, 32'h0, "miss1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, BASE + 32'h104, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, BASE + 32'h104, 32'h0, 1'b1);
        checkOutput("clr+miss decode_err", 32'(decode_err), 32'h1);
        idleCycle(1'b1);
        checkOutput("clr after decode_err", 32'(decode_err), 32'h0);

        // Reset lands in the access cycle of a write to reg 3.
        busTxn(1'b1, BASE + 32'd8, 32'hCAFE_0002, "pre-reset wr");
        busTxn(1'b0, BASE + 32'd8, 32'h0, "pre-reset rd");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, BASE, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, BASE, 32'h0, 1'b0);
        checkOutput("pre-reset proto_err", 32'(proto_err), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'd12, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, BASE + 32'd12, 32'h0000_1234, 1'b0);
        modelReset();
        checkOutput("mid-reset prdata", prdata, 32'h0);
        checkOutput("mid-reset proto_err", 32'(proto_err), 32'h0);
        checkModel("mid-reset");
        idleCycle(1'b0);
        busTxn(1'b0, BASE + 32'd12, 32'h0, "post-reset reg3");
        busTxn(1'b0, BASE + 32'd8, 32'h0, "post-reset reg2");
        idleCycle(1'b0);
        checkModel("post-reset");

        // Randomized transfers against the model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) idleCycle(logic'($urandom_range(0, 3) == 0));
            busTxn(bit'($urandom_range(0, 1)), randAddr(), $urandom(), $sformatf("rand%0d", n));
            checkModel($sformatf("rand%0d", n));
        end
        idleCycle(1'b0);

        // Counter saturation.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        modelReset();
        idleCycle(1'b0);
        for (int n = 0; n < CNT_MAX + 2; n++) begin
            busTxn(1'b1, BASE + 32'(4 * $urandom_range(0, NUM_REGS - 1)), $urandom(),
                   $sformatf("sat%0d", n));
            checkOutput($sformatf("sat%0d wr_count", n), 32'(wr_count),
                        32'((n + 1 < CNT_MAX) ? n + 1 : CNT_MAX));
        end
        idleCycle(1'b0);
        checkModel("sat");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
